// File: rtl/fixed_arith_pkg.sv
// fixed_arith_pkg: shared fixed-point helpers and skid-buffer occupancy states
package fixed_arith_pkg;
  localparam int ACC_W = 64;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  function automatic acc_t floor_shift(input acc_t x, input int sh);
    return x >>> sh;
  endfunction
  function automatic acc_t saturate(input acc_t x, input int w);
    acc_t hi, lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -hi - acc_t'(1);
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: two-entry registered valid/ready buffer; in_ready depends only on occupancy
module skid_buffer_2 import fixed_arith_pkg::*; #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  occ_e occ, occ_nxt;
  logic [DATA_WIDTH-1:0] e1;
  logic push, pop;
  assign in_ready = occ != TWO;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  always_comb begin
    occ_nxt = occ;
    occ_nxt = occ == EMPTY ? (push ? ONE : EMPTY) :
              occ == ONE   ? (push & !pop ? TWO : pop & !push ? EMPTY : ONE) :
                             (pop ? ONE : TWO);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      e1        <= '0;
    end else begin
      occ       <= occ_nxt;
      out_valid <= occ_nxt != EMPTY;
      if (occ == TWO && pop) out_data <= e1;
      else if (push && (occ == EMPTY || pop)) out_data <= in_data;
      if (push && occ == ONE && !pop) e1 <= in_data;
    end
  end
endmodule

// File: rtl/attention_bias_add_join.sv
// attention_bias_add_join: joins data and bias beats, aligns, adds, floors, saturates; tags tensor-last beats
module attention_bias_add_join import fixed_arith_pkg::*; #(
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 8,
  parameter int BIAS_PRECISION_0       = 16,
  parameter int BIAS_PRECISION_1       = 3,
  parameter int DATA_OUT_0_PRECISION_0 = 16,
  parameter int DATA_OUT_0_PRECISION_1 = 8,
  parameter int PARALLELISM            = 1,
  parameter int TENSOR_SIZE_DIM_0      = 32,
  parameter int TENSOR_SIZE_DIM_1      = 4,
  parameter int DEPTH_DIM_0            = TENSOR_SIZE_DIM_0 / PARALLELISM
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [PARALLELISM],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  input  logic [BIAS_PRECISION_0-1:0]       bias [PARALLELISM],
  input  logic                              bias_valid,
  output logic                              bias_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [PARALLELISM],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready,
  output logic                              data_out_0_last
);
  localparam int SH_B = DATA_IN_0_PRECISION_1 - BIAS_PRECISION_1;
  localparam int SH_O = DATA_IN_0_PRECISION_1 - DATA_OUT_0_PRECISION_1;
  localparam int AB_W = BIAS_PRECISION_0 + SH_B;
  localparam int W = (DATA_IN_0_PRECISION_0 > AB_W ? DATA_IN_0_PRECISION_0 : AB_W) + 1;
  localparam int DO_W = DATA_OUT_0_PRECISION_0;
  localparam int DW = PARALLELISM * DO_W + 1;
  localparam int CW_B = DEPTH_DIM_0 > 1 ? $clog2(DEPTH_DIM_0) : 1;
  localparam int CW_R = TENSOR_SIZE_DIM_1 > 1 ? $clog2(TENSOR_SIZE_DIM_1) : 1;
  if (BIAS_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_bad_bias_frac
    $error("BIAS_PRECISION_1 must not exceed DATA_IN_0_PRECISION_1");
  end
  if (DATA_OUT_0_PRECISION_1 > DATA_IN_0_PRECISION_1) begin : g_bad_out_frac
    $error("DATA_OUT_0_PRECISION_1 must not exceed DATA_IN_0_PRECISION_1");
  end
  if (W > ACC_W) begin : g_too_wide
    $error("sum width exceeds fixed_arith_pkg accumulator width");
  end
  logic space, fire, beat_wrap, row_wrap, last;
  logic [CW_B-1:0] beat_cnt;
  logic [CW_R-1:0] row_cnt;
  logic [DW-1:0] in_word, out_word;
  // bias_ready must never rise on a cycle that cannot fire, or the bias source slips
  assign data_in_0_ready = rst & bias_valid & space;
  assign bias_ready = rst & data_in_0_valid & space;
  assign fire = data_in_0_valid & bias_valid & space;
  assign beat_wrap = beat_cnt == CW_B'(DEPTH_DIM_0 - 1);
  assign row_wrap = row_cnt == CW_R'(TENSOR_SIZE_DIM_1 - 1);
  assign last = beat_wrap & row_wrap;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      row_cnt  <= '0;
    end else if (fire) begin
      beat_cnt <= beat_wrap ? '0 : beat_cnt + 1'b1;
      if (beat_wrap) row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
    end
  end
  for (genvar i = 0; i < PARALLELISM; i++) begin : g_lane
    logic signed [W-1:0] d_ext, b_ext, sum;
    assign d_ext = W'($signed(data_in_0[i]));
    assign b_ext = W'($signed(bias[i])) <<< SH_B;
    assign sum = d_ext + b_ext;
    assign in_word[i*DO_W +: DO_W] = DO_W'(saturate(floor_shift(acc_t'(sum), SH_O), DO_W));
    assign data_out_0[i] = out_word[i*DO_W +: DO_W];
  end
  assign in_word[DW-1] = last;
  assign data_out_0_last = out_word[DW-1];
  skid_buffer_2 #(.DATA_WIDTH(DW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_word),
    .in_valid  (data_in_0_valid & bias_valid),
    .in_ready  (space),
    .out_data  (out_word),
    .out_valid (data_out_0_valid),
    .out_ready (data_out_0_ready)
  );
endmodule

// File: tb/tb_attention_bias_add_join.sv
// tb_attention_bias_add_join: random join/backpressure/reset stimulus checked against a queue-based model
module tb_attention_bias_add_join;
  localparam int DI1 = 8, B1 = 3, DO0 = 16, DO1 = 8, P = 1, TS0 = 32, TS1 = 4;
  localparam int BEATS = TS0 / P * TS1;
  logic clk = 0, rst = 1;
  logic [15:0] din [P], bin [P], dout [P];
  logic dv = 0, bv = 0, din_rdy, b_rdy, ov, ordy = 0, olast;
  typedef struct {logic [15:0] v; bit last;} exp_t;
  exp_t q[$];
  int checks = 0, passes = 0, fired = 0, lasts = 0;
  always #5 clk = ~clk;
  attention_bias_add_join dut (
    .clk(clk), .rst(rst),
    .data_in_0(din), .data_in_0_valid(dv), .data_in_0_ready(din_rdy),
    .bias(bin), .bias_valid(bv), .bias_ready(b_rdy),
    .data_out_0(dout), .data_out_0_valid(ov), .data_out_0_ready(ordy),
    .data_out_0_last(olast)
  );
  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask
  function automatic logic [15:0] model(input logic [15:0] d, input logic [15:0] b);
    longint s, dvsr, hi, lo;
    s = longint'($signed(d)) + longint'($signed(b)) * (longint'(1) << (DI1 - B1));
    dvsr = longint'(1) << (DI1 - DO1);
    s = s >= 0 ? s / dvsr : -((-s + dvsr - 1) / dvsr);
    hi = (longint'(1) << (DO0 - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s[15:0];
  endfunction
  always @(negedge clk) begin
    int sz;
    if (!rst) begin
      chk(ov == 0 && olast == 0 && dout[0] == 0, "reset_outputs", {ov, olast, dout[0]}, 0);
      chk(!din_rdy && !b_rdy, "reset_readies", {din_rdy, b_rdy}, 0);
      q.delete();
      fired = 0;
    end else begin
      sz = q.size();
      chk(din_rdy == (bv && sz < 2), "data_in_0_ready", din_rdy, bv && sz < 2);
      chk(b_rdy == (dv && sz < 2), "bias_ready", b_rdy, dv && sz < 2);
      chk(ov == (sz > 0), "data_out_0_valid", ov, sz > 0);
      if (ov && sz > 0) begin
        chk(dout[0] == q[0].v && olast == q[0].last, "data_out_0", {olast, dout[0]}, {q[0].last, q[0].v});
        if (ordy) begin
          if (olast) lasts++;
          void'(q.pop_front());
        end
      end
      if (dv && bv && sz < 2) begin
        q.push_back('{v: model(din[0], bin[0]), last: (fired % BEATS) == BEATS - 1});
        fired++;
      end
    end
  end
  task automatic send(input logic [15:0] d, input logic [15:0] b, input logic [15:0] e, input string nm);
    int n = 0;
    @(posedge clk); #1;
    dv = 1; bv = 1; din[0] = d; bin[0] = b; ordy = 1;
    @(negedge clk);
    while (!din_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(din_rdy, {nm, "_fire"}, din_rdy, 1);
    @(posedge clk); #1;
    dv = 0; bv = 0;
    @(negedge clk);
    chk(ov && dout[0] == e, nm, dout[0], e);
  endtask
  task automatic run_until(input int target, input int dv_pct, input bit bv_hold, input int rdy_pct);
    int n = 0;
    while (n < 5000) begin
      @(posedge clk); #1;
      if (fired >= target) break;
      dv = $urandom_range(99) < dv_pct;
      bv = bv_hold || $urandom_range(99) < 80;
      din[0] = 16'($urandom);
      bin[0] = $urandom_range(1) ? 16'($urandom) : 16'($urandom_range(511) - 256);
      ordy = $urandom_range(99) < rdy_pct;
      n++;
    end
    dv = 0; bv = 0;
    chk(fired == target, "progress", fired, target);
  endtask
  initial begin
    din[0] = 0; bin[0] = 0;
    #2 rst = 0;
    ordy = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk(model(16'h0100, 16'h0008) == 16'h0200, "model_pin_add", model(16'h0100, 16'h0008), 16'h0200);
    chk(model(16'h0080, 16'hFFFF) == 16'h0060, "model_pin_neg", model(16'h0080, 16'hFFFF), 16'h0060);
    send(16'h0100, 16'h0008, 16'h0200, "basic_add");
    send(16'h7F00, 16'h0400, 16'h7FFF, "pos_sat");
    send(16'h8000, 16'hFFF8, 16'h8000, "neg_sat");
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    run_until(32, 60, 1, 100);
    @(posedge clk); #1;
    dv = 1; bv = 1; ordy = 0; din[0] = 16'h1234; bin[0] = 16'h0011;
    repeat (5) @(posedge clk);
    #1 chk(q.size() == 2 && ov && !din_rdy, "backpressure_fill", q.size(), 2);
    dv = 0; bv = 0; ordy = 1;
    run_until(BEATS, 70, 0, 70);
    run_until(BEATS + 50, 90, 0, 80);
    rst = 0;
    #1 chk(ov == 0, "reset_drops_valid", ov, 0);
    chk(lasts == 1, "lasts_first_tensor", lasts, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    run_until(BEATS, 80, 0, 90);
    ordy = 1;
    repeat (5) @(posedge clk);
    #1 chk(q.size() == 0, "drained", q.size(), 0);
    chk(lasts == 2, "lasts_total", lasts, 2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
